// File: rtl/ps2_num_entry_if.sv
// Bus between the PS/2 byte source / MMIO reader and the number-entry block.
// Parameterise MAX_DIGITS to match the attached ps2_num_entry instance.
interface ps2_num_entry_if #(
    parameter int unsigned MAX_DIGITS = 9
);
    logic [7:0]              ps2_scancode;
    logic                    ps2_key_pressed;
    logic                    num_ack;
    logic [31:0]             num_buffer;
    logic                    num_valid;
    logic [4*MAX_DIGITS-1:0] entry_bcd;
    logic [3:0]              digit_count;
    logic                    busy;
    logic                    overflow;

    modport master (
        output ps2_scancode, ps2_key_pressed, num_ack,
        input  num_buffer, num_valid, entry_bcd, digit_count, busy, overflow
    );

    modport slave (
        input  ps2_scancode, ps2_key_pressed, num_ack,
        output num_buffer, num_valid, entry_bcd, digit_count, busy, overflow
    );
endinterface

// File: rtl/ps2_num_entry.sv
// PS/2 set-2 scancode decoder feeding a decimal entry buffer, with a serial
// BCD-to-binary converter and a valid/ack result register for the CPU.
module ps2_num_entry #(
    parameter int unsigned MAX_DIGITS = 9
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    ps2_num_entry_if.slave  bus
);
    localparam int unsigned W = 4 * MAX_DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} dec_state_t;

    dec_state_t    state_q, state_d;
    logic [W-1:0]  entry_q, entry_d;
    logic [W-1:0]  snap_q, snap_d;
    logic [3:0]    count_q, count_d;
    logic [3:0]    step_q, step_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   buf_q, buf_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;

    logic          make, ext_enter, idle_ok, start;
    logic [4:0]    dig;
    logic [31:0]   acc_next;

    // {hit, value}; main-row and keypad codes both map to 0..9
    function automatic logic [4:0] decode_digit(input logic [7:0] sc);
        logic [4:0] r;
        case (sc)
            8'h45, 8'h70: r = {1'b1, 4'd0};
            8'h16, 8'h69: r = {1'b1, 4'd1};
            8'h1E, 8'h72: r = {1'b1, 4'd2};
            8'h26, 8'h7A: r = {1'b1, 4'd3};
            8'h25, 8'h6B: r = {1'b1, 4'd4};
            8'h2E, 8'h73: r = {1'b1, 4'd5};
            8'h36, 8'h74: r = {1'b1, 4'd6};
            8'h3D, 8'h6C: r = {1'b1, 4'd7};
            8'h3E, 8'h75: r = {1'b1, 4'd8};
            8'h46, 8'h7D: r = {1'b1, 4'd9};
            default:      r = '0;
        endcase
        return r;
    endfunction

    assign dig      = decode_digit(bus.ps2_scancode);
    assign idle_ok  = !busy_q && !valid_q;
    assign acc_next = acc_q * 32'd10 + {28'd0, snap_q[W-1 -: 4]};

    always_comb begin
        state_d   = state_q;
        make      = 1'b0;
        ext_enter = 1'b0;
        if (bus.ps2_key_pressed) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.ps2_scancode == 8'hF0)      state_d = S_BRK;
                    else if (bus.ps2_scancode == 8'hE0) state_d = S_EXT;
                    else                                make    = 1'b1;
                end
                S_EXT: begin
                    if (bus.ps2_scancode == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        state_d   = S_IDLE;
                        ext_enter = (bus.ps2_scancode == 8'h5A);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign start = idle_ok && (count_q != 4'd0) &&
                   (ext_enter || (make && bus.ps2_scancode == 8'h5A));

    always_comb begin
        entry_d = entry_q;
        snap_d  = snap_q;
        count_d = count_q;
        step_d  = step_q;
        acc_d   = acc_q;
        buf_d   = buf_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        valid_d = valid_q;

        if (make && bus.ps2_scancode == 8'h76) begin
            entry_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (make && idle_ok) begin
            if (dig[4]) begin
                if (count_q < 4'(MAX_DIGITS)) begin
                    entry_d = (entry_q << 4) | W'(dig[3:0]);
                    count_d = count_q + 4'd1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (bus.ps2_scancode == 8'h66) begin
                if (count_q != 4'd0) begin
                    entry_d = entry_q >> 4;
                    count_d = count_q - 4'd1;
                end
                ovf_d = 1'b0;
            end
        end

        if (start) begin
            busy_d = 1'b1;
            snap_d = entry_q;
            acc_d  = '0;
            step_d = '0;
        end

        if (bus.num_ack && valid_q) valid_d = 1'b0;

        // Completion is evaluated after the ack so a coincident set wins.
        if (busy_q) begin
            acc_d  = acc_next;
            snap_d = snap_q << 4;
            step_d = step_q + 4'd1;
            if (step_q == 4'(MAX_DIGITS - 1)) begin
                buf_d   = acc_next;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                entry_d = '0;
                count_d = '0;
                ovf_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            entry_q <= '0;
            snap_q  <= '0;
            count_q <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            buf_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            snap_q  <= snap_d;
            count_q <= count_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            buf_q   <= buf_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign bus.num_buffer  = buf_q;
    assign bus.num_valid   = valid_q;
    assign bus.entry_bcd   = entry_q;
    assign bus.digit_count = count_q;
    assign bus.busy        = busy_q;
    assign bus.overflow    = ovf_q;
endmodule
